// File: rtl/jtag_mem_pkg.sv
// Shared types and status codes for the JTAG memory burst master.
package jtag_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHECK      = 3'd1,
    ST_WAIT_WDATA = 3'd2,
    ST_BUS_REQ    = 3'd3,
    ST_RESP       = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERROR      = 3'd6
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISALIGN = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_LEN      = 3'd3;
  localparam logic [2:0] ERR_DENIED   = 3'd4;
  localparam logic [2:0] ERR_BUS      = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd6;
  localparam logic [2:0] ERR_ABORT    = 3'd7;

  // True when a status code reports any failure.
  function automatic logic is_fail(input logic [2:0] code);
    return code != ERR_NONE;
  endfunction

endpackage

// File: rtl/jtag_mem_range_check.sv
// Combinational command validation: access policy, length, alignment and
// window bounds. The first failing check in priority order sets the code.
module jtag_mem_range_check
  import jtag_mem_pkg::*;
#(
  parameter int              ADDR_WIDTH   = 32,
  parameter int              DATA_WIDTH   = 32,
  parameter longint unsigned BASE_ADDR    = 64'd0,
  parameter longint unsigned WINDOW_BYTES = 64'd4096,
  parameter int              MAX_BURST    = 16,
  parameter int              LEN_W        = $clog2(MAX_BURST + 1),
  parameter logic [7:0]      MIN_LEVEL    = 8'h80
) (
  input  logic                  debug_mode,
  input  logic [7:0]            access_level,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_W-1:0]      len,
  output logic [2:0]            code
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int AW1 = ADDR_WIDTH + 1;
  // One extra bit so a burst that wraps the address space reads as out of range.
  localparam logic [AW1-1:0] WIN_LO = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0] WIN_HI = AW1'(BASE_ADDR + WINDOW_BYTES);

  logic [AW1-1:0] burst_end_s;
  logic           denied_s;
  logic           bad_len_s;
  logic           misaligned_s;
  logic           out_of_range_s;

  // Evaluate every rule, then pick the highest-priority failure.
  always_comb begin
    burst_end_s    = {1'b0, addr} + (AW1'(len) * AW1'(BPW));
    denied_s       = !debug_mode && (access_level < MIN_LEVEL);
    bad_len_s      = (len == {LEN_W{1'b0}}) || (len > LEN_W'(MAX_BURST));
    misaligned_s   = (addr % ADDR_WIDTH'(BPW)) != {ADDR_WIDTH{1'b0}};
    out_of_range_s = ({1'b0, addr} < WIN_LO) || (burst_end_s > WIN_HI);
    if (denied_s) begin
      code = ERR_DENIED;
    end else if (bad_len_s) begin
      code = ERR_LEN;
    end else if (misaligned_s) begin
      code = ERR_MISALIGN;
    end else if (out_of_range_s) begin
      code = ERR_RANGE;
    end else begin
      code = ERR_NONE;
    end
  end

endmodule

// File: rtl/jtag_mem_burst_master.sv
// JTAG-side memory burst engine: validates a command, then runs it as
// single-beat request/ack handshakes on the system bus. All outputs are
// registered from the next state so they change only on clock edges.
module jtag_mem_burst_master
  import jtag_mem_pkg::*;
#(
  parameter int              ADDR_WIDTH     = 32,
  parameter int              DATA_WIDTH     = 32,
  parameter longint unsigned BASE_ADDR      = 64'd0,
  parameter longint unsigned WINDOW_BYTES   = 64'd4096,
  parameter int              MAX_BURST      = 16,
  parameter int              TIMEOUT_CYCLES = 64,
  parameter logic [7:0]      MIN_LEVEL      = 8'h80,
  localparam int             BPW            = DATA_WIDTH / 8,
  localparam int             LEN_W          = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [BPW-1:0]        cmd_strb,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_code,
  input  logic                  debug_mode,
  input  logic [7:0]            access_level,
  input  logic                  abort,
  output logic                  sys_req,
  output logic                  sys_write,
  output logic [ADDR_WIDTH-1:0] sys_addr,
  output logic [DATA_WIDTH-1:0] sys_wdata,
  output logic [BPW-1:0]        sys_strb,
  input  logic                  sys_ack,
  input  logic                  sys_err,
  input  logic [DATA_WIDTH-1:0] sys_rdata
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_r;
  state_t                next_state_s;
  logic [2:0]            fail_code_s;
  logic [2:0]            chk_code_s;
  logic                  accept_s;
  logic                  beat_ok_s;
  logic                  timeout_s;
  logic                  cmd_write_r;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [LEN_W-1:0]      remain_r;
  logic [BPW-1:0]        strb_r;
  logic [TO_W-1:0]       wait_cnt_r;

  assign accept_s  = (state_r == ST_IDLE) && cmd_ready && cmd_valid;
  assign beat_ok_s = (state_r == ST_BUS_REQ) && sys_ack && !sys_err;
  assign timeout_s = wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1);

  jtag_mem_range_check #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .BASE_ADDR   (BASE_ADDR),
    .WINDOW_BYTES(WINDOW_BYTES),
    .MAX_BURST   (MAX_BURST),
    .LEN_W       (LEN_W),
    .MIN_LEVEL   (MIN_LEVEL)
  ) u_range_check (
    .debug_mode  (debug_mode),
    .access_level(access_level),
    .addr        (cur_addr_r),
    .len         (remain_r),
    .code        (chk_code_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and the failure code to record on entry to ERROR.
  always_comb begin
    next_state_s = state_r;
    fail_code_s  = ERR_NONE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (is_fail(chk_code_s)) begin
          next_state_s = ST_ERROR;
          fail_code_s  = chk_code_s;
        end else if (cmd_write_r) begin
          next_state_s = ST_WAIT_WDATA;
        end else begin
          next_state_s = ST_BUS_REQ;
        end
      end
      ST_WAIT_WDATA: begin
        if (abort) begin
          next_state_s = ST_ERROR;
          fail_code_s  = ERR_ABORT;
        end else if (wdata_valid) begin
          next_state_s = ST_BUS_REQ;
        end else begin
          next_state_s = ST_WAIT_WDATA;
        end
      end
      ST_BUS_REQ: begin
        // A bus error beats an ack; an ack in the final cycle beats the timeout.
        if (sys_err) begin
          next_state_s = ST_ERROR;
          fail_code_s  = ERR_BUS;
        end else if (sys_ack) begin
          if (remain_r == LEN_W'(1)) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_RESP;
          end
        end else if (timeout_s) begin
          next_state_s = ST_ERROR;
          fail_code_s  = ERR_TIMEOUT;
        end else begin
          next_state_s = ST_BUS_REQ;
        end
      end
      ST_RESP: begin
        if (abort) begin
          next_state_s = ST_ERROR;
          fail_code_s  = ERR_ABORT;
        end else if (cmd_write_r) begin
          next_state_s = ST_WAIT_WDATA;
        end else begin
          next_state_s = ST_BUS_REQ;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      ST_ERROR: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Command latch plus per-beat address advance and remaining-beat count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_write_r <= 1'b0;
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      remain_r    <= {LEN_W{1'b0}};
      strb_r      <= {BPW{1'b0}};
    end else if (accept_s) begin
      cmd_write_r <= cmd_write;
      cur_addr_r  <= cmd_addr;
      remain_r    <= cmd_len;
      strb_r      <= cmd_strb;
    end else if (beat_ok_s) begin
      cur_addr_r  <= cur_addr_r + ADDR_WIDTH'(BPW);
      remain_r    <= remain_r - LEN_W'(1);
    end else begin
      cur_addr_r  <= cur_addr_r;
      remain_r    <= remain_r;
    end
  end

  // Counts cycles spent waiting for sys_ack on the current beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_BUS_REQ) begin
      wait_cnt_r <= wait_cnt_r + TO_W'(1);
    end else begin
      wait_cnt_r <= {TO_W{1'b0}};
    end
  end

  // Handshake and bus outputs; sys_* are loaded once per beat and held stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      sys_req     <= 1'b0;
      sys_write   <= 1'b0;
      sys_addr    <= {ADDR_WIDTH{1'b0}};
      sys_wdata   <= {DATA_WIDTH{1'b0}};
      sys_strb    <= {BPW{1'b0}};
    end else begin
      cmd_ready   <= next_state_s == ST_IDLE;
      wdata_ready <= next_state_s == ST_WAIT_WDATA;
      sys_req     <= next_state_s == ST_BUS_REQ;
      if ((next_state_s == ST_BUS_REQ) && (state_r != ST_BUS_REQ)) begin
        sys_write <= cmd_write_r;
        sys_addr  <= cur_addr_r;
        sys_strb  <= cmd_write_r ? strb_r : {BPW{1'b1}};
      end else begin
        sys_write <= sys_write;
        sys_addr  <= sys_addr;
        sys_strb  <= sys_strb;
      end
      if ((state_r == ST_WAIT_WDATA) && (next_state_s == ST_BUS_REQ)) begin
        sys_wdata <= wdata;
      end else begin
        sys_wdata <= sys_wdata;
      end
    end
  end

  // Read-beat return and completion status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= {DATA_WIDTH{1'b0}};
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      rdata_valid <= beat_ok_s && !cmd_write_r;
      rdata_last  <= beat_ok_s && !cmd_write_r && (next_state_s == ST_DONE);
      if (beat_ok_s && !cmd_write_r) begin
        rdata <= sys_rdata;
      end else begin
        rdata <= rdata;
      end
      done <= (next_state_s == ST_DONE) || (next_state_s == ST_ERROR);
      if (accept_s) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end else if (next_state_s == ST_ERROR) begin
        err      <= 1'b1;
        err_code <= fail_code_s;
      end else begin
        err      <= err;
        err_code <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_jtag_mem_burst_master.sv
// Directed bench for jtag_mem_burst_master: a zero-wait bus responder that
// returns the request address as read data, per-cycle output logs taken
// relative to command accept, and hand-computed expectations.
module tb_jtag_mem_burst_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [3:0]  cmd_strb;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_last, done, err;
  logic [31:0] rdata;
  logic [2:0]  err_code;
  logic        debug_mode, abort;
  logic [7:0]  access_level;
  logic        sys_req, sys_write, sys_ack, sys_err;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_strb;

  logic        ack_en;
  logic [31:0] err_addr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic        req_l[64], rv_l[64], last_l[64], done_l[64], err_l[64], wrdy_l[64], rdy_l[64], sw_l[64];
  logic [31:0] rd_l[64], addr_l[64], wd_l[64];
  logic [3:0]  strb_l[64];
  logic [2:0]  ec_l[64];

  always #5 clk = ~clk;

  // Zero-wait responder: read data mirrors the address, error on a chosen address.
  assign sys_ack   = sys_req & ack_en;
  assign sys_err   = sys_req & (sys_addr == err_addr);
  assign sys_rdata = sys_addr;

  jtag_mem_burst_master #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_strb(cmd_strb),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done(done), .err(err), .err_code(err_code),
    .debug_mode(debug_mode), .access_level(access_level), .abort(abort),
    .sys_req(sys_req), .sys_write(sys_write), .sys_addr(sys_addr),
    .sys_wdata(sys_wdata), .sys_strb(sys_strb),
    .sys_ack(sys_ack), .sys_err(sys_err), .sys_rdata(sys_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and log every output for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 64) begin
      req_l[cyc] = sys_req;   rv_l[cyc]  = rdata_valid; last_l[cyc] = rdata_last;
      done_l[cyc] = done;     err_l[cyc] = err;         wrdy_l[cyc] = wdata_ready;
      rdy_l[cyc] = cmd_ready; sw_l[cyc]  = sys_write;   rd_l[cyc]   = rdata;
      addr_l[cyc] = sys_addr; wd_l[cyc]  = sys_wdata;   strb_l[cyc] = sys_strb;
      ec_l[cyc] = err_code;
    end
  endtask

  // Present a command in cycle 0; returns in cycle 1 after the accept edge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [4:0] l, input logic [3:0] s);
    for (int i = 0; i < 64; i++) begin
      req_l[i] = 1'b0; rv_l[i] = 1'b0; done_l[i] = 1'b0; last_l[i] = 1'b0;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_strb = s; cmd_valid = 1'b1;
    cyc = 0;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  function automatic int count_req(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(req_l[i]);
    return n;
  endfunction

  function automatic int count_rv(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(rv_l[i]);
    return n;
  endfunction

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
    cmd_len = 5'd0; cmd_strb = 4'd0; wdata_valid = 1'b0; wdata = 32'd0;
    debug_mode = 1'b0; access_level = 8'h80; abort = 1'b0;
    ack_en = 1'b1; err_addr = 32'hFFFF_FFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_sys_req", 32'(sys_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 4-beat zero-wait read from 0x10
    send_cmd(1'b0, 32'h10, 5'd4, 4'hF);
    run_to(11);
    chk("rd4_req_c2", 32'(req_l[2]), 32'd1);
    chk("rd4_req_gap_c3", 32'(req_l[3]), 32'd0);
    chk("rd4_req_count", 32'(count_req(1, 11)), 32'd4);
    chk("rd4_rv_count", 32'(count_rv(1, 11)), 32'd4);
    chk("rd4_rv_c3", 32'(rv_l[3]), 32'd1);
    chk("rd4_rdata_c3", rd_l[3], 32'h10);
    chk("rd4_rdata_c5", rd_l[5], 32'h14);
    chk("rd4_rdata_c7", rd_l[7], 32'h18);
    chk("rd4_rdata_c9", rd_l[9], 32'h1C);
    chk("rd4_last_c7", 32'(last_l[7]), 32'd0);
    chk("rd4_last_c9", 32'(last_l[9]), 32'd1);
    chk("rd4_done_c8", 32'(done_l[8]), 32'd0);
    chk("rd4_done_c9", 32'(done_l[9]), 32'd1);
    chk("rd4_err_c9", 32'(err_l[9]), 32'd0);
    chk("rd4_ready_c9", 32'(rdy_l[9]), 32'd0);
    chk("rd4_ready_c10", 32'(rdy_l[10]), 32'd1);

    // Single write at the top of the window with partial strobes
    wdata = 32'hCAFE_0011; wdata_valid = 1'b1;
    send_cmd(1'b1, 32'hFFC, 5'd1, 4'b0011);
    run_to(6);
    wdata_valid = 1'b0;
    chk("wr1_wready_c2", 32'(wrdy_l[2]), 32'd1);
    chk("wr1_req_count", 32'(count_req(1, 6)), 32'd1);
    chk("wr1_req_c3", 32'(req_l[3]), 32'd1);
    chk("wr1_strb", 32'(strb_l[3]), 32'h3);
    chk("wr1_addr", addr_l[3], 32'hFFC);
    chk("wr1_write", 32'(sw_l[3]), 32'd1);
    chk("wr1_wdata", wd_l[3], 32'hCAFE_0011);
    chk("wr1_done_c4", 32'(done_l[4]), 32'd1);
    chk("wr1_errcode", 32'(ec_l[4]), 32'd0);

    // Two beats from 0xFFC cross the window end
    send_cmd(1'b1, 32'hFFC, 5'd2, 4'hF);
    run_to(4);
    chk("range_done_c2", 32'(done_l[2]), 32'd1);
    chk("range_err_c2", 32'(err_l[2]), 32'd1);
    chk("range_code", 32'(ec_l[2]), 32'd2);
    chk("range_no_req", 32'(count_req(1, 4)), 32'd0);

    // Denied outranks misalignment
    access_level = 8'h7F;
    send_cmd(1'b0, 32'h2, 5'd1, 4'hF);
    run_to(4);
    access_level = 8'h80;
    chk("deny_done_c1", 32'(done_l[1]), 32'd0);
    chk("deny_done_c2", 32'(done_l[2]), 32'd1);
    chk("deny_code", 32'(ec_l[2]), 32'd4);
    chk("deny_no_req", 32'(count_req(1, 4)), 32'd0);

    // Misaligned with sufficient level; then zero length outranks misalignment
    send_cmd(1'b0, 32'h2, 5'd1, 4'hF);
    run_to(3);
    chk("misalign_code", 32'(ec_l[2]), 32'd1);
    send_cmd(1'b0, 32'h2, 5'd0, 4'hF);
    run_to(3);
    chk("len0_code", 32'(ec_l[2]), 32'd3);
    send_cmd(1'b0, 32'h0, 5'd17, 4'hF);
    run_to(3);
    chk("len17_code", 32'(ec_l[2]), 32'd3);

    // debug_mode overrides a low access level
    debug_mode = 1'b1; access_level = 8'h00;
    send_cmd(1'b0, 32'h20, 5'd1, 4'hF);
    run_to(4);
    debug_mode = 1'b0; access_level = 8'h80;
    chk("dbg_done_c3", 32'(done_l[3]), 32'd1);
    chk("dbg_code", 32'(ec_l[3]), 32'd0);

    // Timeout: no ack, sys_req high for 8 cycles then ERROR
    ack_en = 1'b0;
    send_cmd(1'b0, 32'h0, 5'd1, 4'hF);
    run_to(12);
    ack_en = 1'b1;
    chk("to_req_count", 32'(count_req(1, 12)), 32'd8);
    chk("to_req_c9", 32'(req_l[9]), 32'd1);
    chk("to_req_c10", 32'(req_l[10]), 32'd0);
    chk("to_done_c9", 32'(done_l[9]), 32'd0);
    chk("to_done_c10", 32'(done_l[10]), 32'd1);
    chk("to_code", 32'(ec_l[10]), 32'd6);

    // ack and err together on beat 2 of 3
    err_addr = 32'h24;
    send_cmd(1'b0, 32'h20, 5'd3, 4'hF);
    run_to(7);
    err_addr = 32'hFFFF_FFFF;
    chk("berr_rv_count", 32'(count_rv(1, 7)), 32'd1);
    chk("berr_done_c5", 32'(done_l[5]), 32'd1);
    chk("berr_code", 32'(ec_l[5]), 32'd5);
    chk("berr_err_held", 32'(err_l[7]), 32'd1);

    // abort is ignored while a beat is outstanding
    ack_en = 1'b0;
    send_cmd(1'b0, 32'h50, 5'd1, 4'hF);
    run_to(2);
    abort = 1'b1;
    run_to(4);
    abort = 1'b0; ack_en = 1'b1;
    run_to(6);
    chk("abus_done_c5", 32'(done_l[5]), 32'd1);
    chk("abus_code", 32'(ec_l[5]), 32'd0);
    chk("abus_rdata", rd_l[5], 32'h50);

    // abort while waiting for the second write beat
    wdata = 32'h1234_5678; wdata_valid = 1'b1;
    send_cmd(1'b1, 32'h40, 5'd2, 4'hF);
    run_to(3);
    wdata_valid = 1'b0;
    run_to(5);
    abort = 1'b1;
    run_to(6);
    abort = 1'b0;
    run_to(7);
    chk("abort_wready_c5", 32'(wrdy_l[5]), 32'd1);
    chk("abort_req_count", 32'(count_req(1, 7)), 32'd1);
    chk("abort_done_c6", 32'(done_l[6]), 32'd1);
    chk("abort_code", 32'(ec_l[6]), 32'd7);

    // Reset in the middle of a bus request
    ack_en = 1'b0;
    send_cmd(1'b0, 32'h60, 5'd2, 4'hF);
    run_to(2);
    chk("mid_rst_req_before", 32'(sys_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_req_drop", 32'(sys_req), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; ack_en = 1'b1;
    step();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_code", 32'(err_code), 32'd0);
    chk("post_rst_req", 32'(sys_req), 32'd0);

    // Engine usable again after reset
    send_cmd(1'b0, 32'h30, 5'd1, 4'hF);
    run_to(4);
    chk("post_rst_rd_done", 32'(done_l[3]), 32'd1);
    chk("post_rst_rd_data", rd_l[3], 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
